// File: rtl/ctc_pkg.sv
// Shared constants for the two-channel I/O counter/timer: register selects,
// mode bit positions and status bit positions.
package ctc_pkg;
    localparam int NUM_CH = 2;

    localparam logic [2:0] CTC_STAT0 = 3'd0;
    localparam logic [2:0] CTC_STAT1 = 3'd1;
    localparam logic [2:0] CTC_MODE0 = 3'd2;
    localparam logic [2:0] CTC_MODE1 = 3'd3;
    localparam logic [2:0] CTC_INIT0 = 3'd4;
    localparam logic [2:0] CTC_INIT1 = 3'd5;

    localparam int MODE_SEL = 0;
    localparam int MODE_RPT = 1;

    localparam int STAT_ACTIVE = 15;
    localparam int STAT_DONE   = 0;
endpackage

// File: rtl/io_ctc16_if.sv
// I/O bus seen by the counter/timer: chip select, read/write strobes,
// halfword register select, write data and combinational read data.
interface io_ctc16_if;
    logic        cs;
    logic        io_read;
    logic        io_write;
    logic [2:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;

    modport master (output cs, io_read, io_write, addr, wdata, input rdata);
    modport slave  (input cs, io_read, io_write, addr, wdata, output rdata);
endinterface

// File: rtl/io_ctc_channel.sv
// One counter/timer channel: mode/init/count registers, external pulse
// synchronizer with rising-edge detect, and expiry handling.
module io_ctc_channel
    import ctc_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        tick_timer,
    input  logic        pulse,
    input  logic        mode_we,
    input  logic        init_we,
    input  logic        stat_rd,
    input  logic [15:0] wdata,
    output logic [15:0] count,
    output logic        active,
    output logic        done,
    output logic        cout
);
    logic [1:0]  mode;
    logic [15:0] init;
    logic [2:0]  sync;
    logic        tick;

    // sync[1] is the synchronized input, sync[2] its previous value.
    assign tick = mode[MODE_SEL] ? (sync[1] & ~sync[2]) : tick_timer;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync   <= '0;
            mode   <= '0;
            init   <= '0;
            count  <= '0;
            active <= 1'b0;
            done   <= 1'b0;
            cout   <= 1'b0;
        end else begin
            sync <= {sync[1:0], pulse};
            cout <= 1'b0;
            if (stat_rd)
                done <= 1'b0;
            // Writes take priority; a tick landing on a write cycle is lost.
            if (mode_we) begin
                mode   <= wdata[1:0];
                active <= 1'b0;
            end else if (init_we) begin
                init   <= wdata;
                count  <= wdata;
                done   <= 1'b0;
                active <= (wdata != 16'd0);
            end else if (tick && active) begin
                if (count > 16'd1) begin
                    count <= count - 16'd1;
                end else begin
                    done <= 1'b1;
                    cout <= 1'b1;
                    if (mode[MODE_RPT]) begin
                        count <= init;
                    end else begin
                        count  <= 16'd0;
                        active <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: rtl/io_ctc16.sv
// Two-channel 16-bit counter/timer on the I/O bus: shared prescaler,
// register decode and read mux around two channel instances.
module io_ctc16
    import ctc_pkg::*;
#(
    parameter int PRESCALE = 100
) (
    input  logic        clock,
    input  logic        reset_n,
    io_ctc16_if.slave   bus,
    input  logic        pulse0,
    input  logic        pulse1,
    output logic        cout0,
    output logic        cout1
);
    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] pre;
    logic          tick_timer;
    logic          rd, wr;

    logic [NUM_CH-1:0]       pulse, cout, active, done;
    logic [NUM_CH-1:0]       mode_we, init_we, stat_rd;
    logic [NUM_CH-1:0][15:0] count;
    logic [NUM_CH-1:0][15:0] status;
    logic [15:0]             rdata;

    // Free-running; register writes never disturb the phase.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            pre <= '0;
        else if (tick_timer)
            pre <= '0;
        else
            pre <= pre + 1'b1;
    end

    assign tick_timer = (pre == PW'(PRESCALE - 1));
    assign rd         = bus.cs & bus.io_read;
    assign wr         = bus.cs & bus.io_write;
    assign pulse      = {pulse1, pulse0};
    assign cout0      = cout[0];
    assign cout1      = cout[1];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        localparam logic [2:0] A_STAT = CTC_STAT0 + 3'(g);
        localparam logic [2:0] A_MODE = CTC_MODE0 + 3'(g);
        localparam logic [2:0] A_INIT = CTC_INIT0 + 3'(g);

        assign stat_rd[g] = rd && (bus.addr == A_STAT);
        assign mode_we[g] = wr && (bus.addr == A_MODE);
        assign init_we[g] = wr && (bus.addr == A_INIT);

        io_ctc_channel u_ch (
            .clock      (clock),
            .reset_n    (reset_n),
            .tick_timer (tick_timer),
            .pulse      (pulse[g]),
            .mode_we    (mode_we[g]),
            .init_we    (init_we[g]),
            .stat_rd    (stat_rd[g]),
            .wdata      (bus.wdata),
            .count      (count[g]),
            .active     (active[g]),
            .done       (done[g]),
            .cout       (cout[g])
        );
    end

    always_comb begin
        status = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            status[c][STAT_ACTIVE] = active[c];
            status[c][STAT_DONE]   = done[c];
        end
        rdata = '0;
        if (rd) begin
            case (bus.addr)
                CTC_STAT0: rdata = status[0];
                CTC_STAT1: rdata = status[1];
                CTC_INIT0: rdata = count[0];
                CTC_INIT1: rdata = count[1];
                default:   rdata = '0;
            endcase
        end
    end

    assign bus.rdata = rdata;
endmodule

// File: tb/tb_io_ctc16.sv
// Directed plus randomized bench for io_ctc16 against a cycle-level
// behavioural model of the register rules.
module tb_io_ctc16;
    localparam int PS = 4;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic pulse0 = 1'b0, pulse1 = 1'b0;
    logic cout0, cout1;

    io_ctc16_if bus();

    io_ctc16 #(.PRESCALE(PS)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave),
        .pulse0  (pulse0),
        .pulse1  (pulse1),
        .cout0   (cout0),
        .cout1   (cout1)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    logic [15:0] m_count [2];
    logic [15:0] m_init  [2];
    bit          m_act   [2];
    bit          m_done  [2];
    bit          m_sel   [2];
    bit          m_rpt   [2];
    bit          m_cout  [2];
    int          ncout   [2];
    int          ecount;
    int          cout_edge;
    bit          ph0 [$];
    bit          ph1 [$];
    logic [15:0] last_rd;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            m_count[c] = 0; m_init[c] = 0; m_act[c] = 0; m_done[c] = 0;
            m_sel[c] = 0; m_rpt[c] = 0; m_cout[c] = 0;
        end
        ecount = 0;
        ph0 = '{0, 0, 0};
        ph1 = '{0, 0, 0};
    endfunction

    function automatic logic [15:0] exp_rdata(bit cs, bit rd, logic [2:0] a);
        if (!(cs && rd)) return 16'h0;
        case (a)
            3'd0, 3'd1: return {m_act[a[0]], 14'b0, m_done[a[0]]};
            3'd4, 3'd5: return m_count[a[0]];
            default:    return 16'h0;
        endcase
    endfunction

    // Apply the register rules for one rising edge.
    function automatic void model_edge(bit cs, bit rd, bit wr, logic [2:0] a,
                                       logic [15:0] d, bit p0, bit p1);
        bit ttick;
        ttick = (ecount % PS) == PS - 1;
        for (int c = 0; c < 2; c++) begin
            bit ctick, tick, mw, iw, sr;
            ctick = (c == 0) ? (ph0[$-1] && !ph0[$-2]) : (ph1[$-1] && !ph1[$-2]);
            tick  = m_sel[c] ? ctick : ttick;
            mw = cs && wr && (a == 3'(2 + c));
            iw = cs && wr && (a == 3'(4 + c));
            sr = cs && rd && (a == 3'(c));
            m_cout[c] = 0;
            if (sr) m_done[c] = 0;
            if (mw) begin
                m_sel[c] = d[0]; m_rpt[c] = d[1]; m_act[c] = 0;
            end else if (iw) begin
                m_init[c] = d; m_count[c] = d; m_done[c] = 0; m_act[c] = (d != 0);
            end else if (tick && m_act[c]) begin
                if (m_count[c] > 1) m_count[c] = m_count[c] - 1;
                else begin
                    m_done[c] = 1; m_cout[c] = 1;
                    if (m_rpt[c]) m_count[c] = m_init[c];
                    else begin m_count[c] = 0; m_act[c] = 0; end
                end
            end
        end
        ph0.push_back(p0);
        ph1.push_back(p1);
        ecount++;
    endfunction

    task automatic cyc(bit cs, bit rd, bit wr, logic [2:0] a, logic [15:0] d, bit p0, bit p1);
        bus.cs = cs; bus.io_read = rd; bus.io_write = wr; bus.addr = a; bus.wdata = d;
        pulse0 = p0; pulse1 = p1;
        #1;
        last_rd = bus.rdata;
        chk("rdata", bus.rdata, exp_rdata(cs, rd, a));
        @(posedge clock);
        model_edge(cs, rd, wr, a, d, p0, p1);
        #1;
        chk("cout0", {15'b0, cout0}, {15'b0, m_cout[0]});
        chk("cout1", {15'b0, cout1}, {15'b0, m_cout[1]});
        if (cout0) begin ncout[0]++; cout_edge = ecount; end
        if (cout1) ncout[1]++;
        @(negedge clock);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 3'd0, 16'h0, pulse0, pulse1);
    endtask

    task automatic wr_reg(logic [2:0] a, logic [15:0] d);
        cyc(1, 0, 1, a, d, pulse0, pulse1);
    endtask

    task automatic rd_reg(logic [2:0] a);
        cyc(1, 1, 0, a, 16'h0, pulse0, pulse1);
    endtask

    task automatic align_tick();
        for (int i = 0; i < PS && (ecount % PS) != PS - 1; i++) idle(1);
    endtask

    initial begin
        int w_edge, snap;
        logic [15:0] frozen;
        bus.cs = 0; bus.io_read = 0; bus.io_write = 0; bus.addr = 0; bus.wdata = 0;
        ncout[0] = 0; ncout[1] = 0;
        cout_edge = -1;
        model_reset();
        @(negedge clock); @(negedge clock);
        reset_n = 1'b1;

        // Reset state
        rd_reg(3'd0); chk("rst_stat0", last_rd, 16'h0000);
        rd_reg(3'd1); chk("rst_stat1", last_rd, 16'h0000);
        rd_reg(3'd4); chk("rst_count0", last_rd, 16'h0000);

        // One-shot timer, init 3
        wr_reg(3'd2, 16'h0000);
        wr_reg(3'd4, 16'h0003);
        w_edge = ecount;
        idle(20);
        chk("os_pulses", 16'(ncout[0]), 16'd1);
        chk("os_latency_ok", 16'((cout_edge - w_edge) >= 9 && (cout_edge - w_edge) <= 15), 16'd1);
        rd_reg(3'd0); chk("os_stat_first", last_rd, 16'h0001);
        rd_reg(3'd0); chk("os_stat_second", last_rd, 16'h0000);
        rd_reg(3'd4); chk("os_count", last_rd, 16'h0000);

        // Periodic counter on channel 1
        wr_reg(3'd3, 16'h0003);
        wr_reg(3'd5, 16'h0002);
        ncout[1] = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 0, 3'd0, 16'h0, 0, 1); cyc(0, 0, 0, 3'd0, 16'h0, 0, 1);
            cyc(0, 0, 0, 3'd0, 16'h0, 0, 0); cyc(0, 0, 0, 3'd0, 16'h0, 0, 0);
        end
        idle(4);
        chk("per_pulses", 16'(ncout[1]), 16'd3);
        rd_reg(3'd5); chk("per_count", last_rd, 16'h0002);
        rd_reg(3'd1); chk("per_stat", last_rd, 16'h8001);

        // Init write on the tick cycle drops the tick
        wr_reg(3'd2, 16'h0000);
        wr_reg(3'd4, 16'h0009);
        align_tick();
        wr_reg(3'd4, 16'h0005);
        rd_reg(3'd4); chk("coll_init", last_rd, 16'h0005);

        // Status read on the expiry cycle
        align_tick();
        wr_reg(3'd4, 16'h0001);
        align_tick();
        rd_reg(3'd0); chk("coll_rd_bit0", {15'b0, last_rd[0]}, 16'h0000);
        rd_reg(3'd0); chk("coll_rd_next", last_rd, 16'h0001);

        // Init zero stays inactive
        wr_reg(3'd4, 16'h0000);
        rd_reg(3'd0); chk("init0_stat", last_rd, 16'h0000);
        snap = ncout[0];
        idle(16);
        chk("init0_nocout", 16'(ncout[0] - snap), 16'd0);

        // Mode write mid-count freezes the count
        wr_reg(3'd4, 16'd10);
        idle(9);
        rd_reg(3'd4);
        frozen = last_rd;
        chk("freeze_moved", 16'(frozen < 16'd10), 16'd1);
        wr_reg(3'd2, 16'h0000);
        idle(12);
        rd_reg(3'd4); chk("freeze_hold", last_rd, frozen);

        // Decode isolation
        wr_reg(3'd3, 16'h0000);
        cyc(0, 0, 1, 3'd4, 16'h0007, pulse0, pulse1);
        wr_reg(3'd6, 16'h0003);
        wr_reg(3'd7, 16'h0003);
        wr_reg(3'd0, 16'hffff);
        rd_reg(3'd4); chk("iso_count0", last_rd, frozen);
        rd_reg(3'd0); chk("iso_stat0", last_rd, 16'h0000);
        rd_reg(3'd1); chk("iso_stat1", last_rd, 16'h0000);
        rd_reg(3'd6); chk("iso_rsv6", last_rd, 16'h0000);
        rd_reg(3'd2); chk("iso_mode_rd", last_rd, 16'h0000);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            bit cs, rd, wr, p0, p1;
            logic [2:0]  a;
            logic [15:0] d;
            cs = $urandom_range(0, 3) != 0;
            rd = $urandom_range(0, 2) == 0;
            wr = !rd && ($urandom_range(0, 4) == 0);
            a  = 3'($urandom_range(0, 7));
            d  = (a == 3'd2 || a == 3'd3) ? 16'($urandom_range(0, 3)) : 16'($urandom_range(0, 6));
            p0 = ($urandom_range(0, 2) == 0) ? !pulse0 : pulse0;
            p1 = ($urandom_range(0, 2) == 0) ? !pulse1 : pulse1;
            cyc(cs, rd, wr, a, d, p0, p1);
        end

        // Asynchronous reset mid-count
        wr_reg(3'd2, 16'h0000);
        wr_reg(3'd4, 16'd50);
        idle(7);
        #2 reset_n = 1'b0;
        for (int a = 0; a < 6; a++) begin
            bus.cs = 1; bus.io_read = 1; bus.io_write = 0; bus.addr = 3'(a);
            #1 chk("inrst_rdata", bus.rdata, 16'h0000);
        end
        chk("inrst_cout0", {15'b0, cout0}, 16'h0000);
        chk("inrst_cout1", {15'b0, cout1}, 16'h0000);
        @(negedge clock); @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        rd_reg(3'd0); chk("post_rst_stat0", last_rd, 16'h0000);
        rd_reg(3'd4); chk("post_rst_count0", last_rd, 16'h0000);
        idle(8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/io_ctc16.md
# io_ctc16

Memory-mapped two-channel 16-bit counter/timer that sits on the CPU's I/O bus as the responder for `IORead`/`IOWrite` cycles issued by the control unit. The address decoder asserts the chip select when the ALU result falls in the CTC window. The block then accepts mode and initial-value writes, returns status and live counts on reads, and counts down either prescaled clocks (timer mode) or external pulse edges (counter mode). Each channel raises a one-cycle terminal pulse and a sticky done flag when it expires.

## Interface
- `PRESCALE`, default 100: clocks per timer tick; legal range ≥ 2.
- `clock  in  1`: system clock; all state changes on its rising edge.
- `reset_n  in  1`: asynchronous, active-low reset.
- `cs  in  1`: chip select from the I/O address decoder.
- `io_read  in  1`: I/O read strobe, qualified by `cs`.
- `io_write  in  1`: I/O write strobe, qualified by `cs`.
- `addr  in  3`: register select, equal to byte address bits [3:1] (halfword registers).
- `wdata  in  16`: write data.
- `rdata  out  16`: read data; combinational, valid in the same cycle as `io_read`.
- `pulse0`, `pulse1`  in  1 each: asynchronous external count inputs.
- `cout0`, `cout1`  out  1 each: one-cycle terminal pulse per channel.

## Operation
- Register map by `addr`:
  - 0: status0 (R)
  - 1: status1 (R)
  - 2: mode0 (W)
  - 3: mode1 (W)
  - 4: init0 (W) / count0 (R)
  - 5: init1 (W) / count1 (R)
  - 6–7: reserved; reads return 0 and writes are ignored.
- Mode register bits:
  - bit0 `sel`: 0 = timer, 1 = counter.
  - bit1 `rpt`: 0 = one-shot, 1 = periodic.
  - Writing mode also clears `active` and leaves `count` unchanged.
- Status read returns `{active, 14'b0, done}`. The read clears `done` at the clock edge ending the read cycle.
- Init write:
  - Stores `init`, loads `count` = `wdata`, clears `done`.
  - Sets `active` = 1 if `wdata` ≠ 0; otherwise `active` = 0.
- Tick source:
  - Timer mode: a shared prescaler counts 0..PRESCALE-1 and emits a tick on wrap.
  - Counter mode: `pulseN` passes through a 2-FF synchronizer, and a rising edge of the synchronized signal is the tick.
- On a tick while `active`:
  - If `count` > 1: `count` decrements by 1.
  - If `count` == 1: `count` becomes 0, `done` = 1, `coutN` = 1 for the next cycle.
    - If `rpt` = 1: `count` = `init` and `active` stays 1.
    - If `rpt` = 0: `active` = 0 and `count` holds at 0.
- Ticks while `active` = 0 are ignored; `count` holds.
- Simultaneous events:
  - Init or mode write in the same cycle as a tick: the write wins and the tick is dropped.
  - Status read in the same cycle as expiry: `done` ends at 1 (set wins over clear-on-read). `rdata` shows the pre-edge value.
- Read-only addresses ignore writes. Write-only addresses return 0 on read except 4/5, which return the live count.
- Strobes with `cs` = 0 have no effect, and `rdata` = 0.

## Timing
- Reset: prescaler, all `count`/`init`/mode/`active`/`done` = 0; `cout0` = `cout1` = 0; `rdata` = 0. Reset may assert mid-count, and all state clears immediately.
- Write latency: the register updates at the edge ending the write cycle, and the new value is readable in the next cycle.
- Timer expiry with `init` = N is exactly N·PRESCALE clocks after the write edge, ±(PRESCALE-1) from prescaler phase. The prescaler is free-running and is not reset by writes.
- Counter latency: a `pulseN` rising edge stable at a clock edge becomes a tick 2 cycles later; the count changes at the third edge.
- `coutN` is high for exactly one cycle; in periodic mode there is one pulse per period.
- Pulses narrower than one clock period are not guaranteed to be counted.

## Structure
- Package `ctc_pkg`:
  - Register-select constants `CTC_STAT0`..`CTC_INIT1`.
  - Mode bit positions `MODE_SEL`, `MODE_RPT`.
  - Status bit positions `STAT_ACTIVE`, `STAT_DONE`.
- Sub-module `io_ctc_channel`, instantiated twice. It holds mode, init, count, active and done, plus the synchronizer and edge detector, and takes `tick_timer`, write-enables and a status-read strobe.
- The top level holds the prescaler, address decode and `rdata` mux.

## Test plan
- Reset check: assert `reset_n` = 0 mid-count → all reads return 0, `cout` = 0, `active` = 0.
- One-shot timer: `PRESCALE` = 4, mode0 = 0, init0 = 3 → `cout0` pulses once 12±3 cycles later. After that, status0 = 0x0001, a second read gives 0x0000, and count0 = 0.
- Periodic counter: mode1 = 3, init1 = 2, six `pulse1` edges → three `cout1` pulses; count1 = 2 and status1 = 0x8001.
- Collision cases:
  - Write init0 = 5 on the tick cycle → count0 reads 5.
  - Status0 read on the expiry cycle → `rdata` bit0 = 0, next read bit0 = 1.
- Init zero and mode stop: init0 = 0 → `active` = 0 and no `cout0`. A mode write mid-count freezes count0 at its current value.
- Decode isolation: `io_write` with `cs` = 0, and writes to `addr` 6/7 → no register change; reads of 0–1 return 0x0000 when idle.
